// File: rtl/regfile_pkg.sv
// Shared constants and reset-value helper for the multi-port register file.
// Latency: n/a (package only).
// Backpressure: n/a.
package regfile_pkg;

    // Architectural index of the PC; it is never stored, only served from fetch.
    localparam int REG_PC     = 15;
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    // Reset contents of stored register i under the selected init mode.
    function automatic logic [63:0] init_value(input int i, input int mode);
        logic [63:0] v;
        v = '0;
        if (mode == INIT_INDEX) begin
            v = 64'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per stored register, set on reserve, cleared on writeback.
// Latency: bit updates on the rising edge; rd_pending is combinational from the read addresses.
// Backpressure: none; rd_pending is the stall request consumed by the hazard unit.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int RD_PORTS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    input  logic                       wb_en0,
    input  logic [ADDR_W-1:0]          wb_addr0,
    input  logic                       wb_en1,
    input  logic [ADDR_W-1:0]          wb_addr1,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [RD_PORTS-1:0]        rd_pending
);

    logic [NUM_REGS-1:0] pending;

    // Reserve wins over a same-edge writeback: the newly issued producer supersedes the old one.
    // Virtual addresses never match a loop index, so they are ignored without extra checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rsv_en && rsv_addr == ADDR_W'(r)) begin
                    pending[r] <= 1'b1;
                end else if ((wb_en0 && wb_addr0 == ADDR_W'(r)) ||
                             (wb_en1 && wb_addr1 == ADDR_W'(r))) begin
                    pending[r] <= 1'b0;
                end
            end
        end
    end

    // A pending source is not a hazard if its producer is writing back this very cycle (bypassed).
    always_comb begin
        rd_pending = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            logic [ADDR_W-1:0] a;
            logic              hit;
            logic              pend;
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            hit  = (wb_en0 && wb_addr0 == a) || (wb_en1 && wb_addr1 == a);
            pend = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (a == ADDR_W'(r)) begin
                    pend = pending[r];
                end
            end
            rd_pending[k] = pend && !hit;
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Register file: RD_PORTS combinational read ports, two write ports, same-cycle bypass, pending scoreboard.
// Latency: reads zero-cycle (write data bypassed); writes land on the rising edge; wr_collision one cycle later.
// Backpressure: none; rd_pending tells the hazard unit to stall ID.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 15,
    parameter int RD_PORTS  = 3,
    parameter int INIT_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]  rd_data,
    output logic [RD_PORTS-1:0]        rd_pending,
    input  logic [WIDTH-1:0]           pc_in,
    input  logic                       wb_en0,
    input  logic [ADDR_W-1:0]          wb_addr0,
    input  logic [WIDTH-1:0]           wb_data0,
    input  logic                       wb_en1,
    input  logic [ADDR_W-1:0]          wb_addr1,
    input  logic [WIDTH-1:0]           wb_data1,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       wr_collision
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             collide;

    // Both ports hitting the same stored register; virtual targets are dropped, so never collide.
    assign collide = wb_en0 && wb_en1 && (wb_addr0 == wb_addr1) &&
                     ({1'b0, wb_addr0} < NUM_REGS_W);

    // Storage update: port 0 takes priority over port 1 on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= WIDTH'(init_value(i, INIT_MODE));
            end
            wr_collision <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en0 && wb_addr0 == ADDR_W'(i)) begin
                    regs[i] <= wb_data0;
                end else if (wb_en1 && wb_addr1 == ADDR_W'(i)) begin
                    regs[i] <= wb_data1;
                end
            end
            wr_collision <= collide;
        end
    end

    // Read mux per port: PC for virtual addresses, then port-0 bypass, port-1 bypass, stored value.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            logic [ADDR_W-1:0] a;
            logic [WIDTH-1:0]  stored;
            logic [WIDTH-1:0]  d;
            a      = rd_addr[k*ADDR_W +: ADDR_W];
            stored = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (a == ADDR_W'(i)) begin
                    stored = regs[i];
                end
            end
            if ({1'b0, a} >= NUM_REGS_W) begin
                d = pc_in;
            end else if (wb_en0 && wb_addr0 == a) begin
                d = wb_data0;
            end else if (wb_en1 && wb_addr1 == a) begin
                d = wb_data1;
            end else begin
                d = stored;
            end
            rd_data[k*WIDTH +: WIDTH] = d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RD_PORTS (RD_PORTS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .wb_en0     (wb_en0),
        .wb_addr0   (wb_addr0),
        .wb_en1     (wb_en1),
        .wb_addr1   (wb_addr1),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rd_pending (rd_pending)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for the multi-port register file and its pending-write scoreboard.
// Latency: inputs driven 1 ns after the rising edge, outputs checked 1 ns later.
// Backpressure: n/a.
module tb_regfile_mp_scoreboard;

    localparam int WIDTH    = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 15;
    localparam int RD_PORTS = 3;

    logic                       clk;
    logic                       rst;
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS*WIDTH-1:0]  rd_data;
    logic [RD_PORTS-1:0]        rd_pending;
    logic [WIDTH-1:0]           pc_in;
    logic                       wb_en0;
    logic [ADDR_W-1:0]          wb_addr0;
    logic [WIDTH-1:0]           wb_data0;
    logic                       wb_en1;
    logic [ADDR_W-1:0]          wb_addr1;
    logic [WIDTH-1:0]           wb_data1;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic                       wr_collision;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] expv [NUM_REGS];

    regfile_mp_scoreboard #(
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .RD_PORTS  (RD_PORTS),
        .INIT_MODE (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_pending   (rd_pending),
        .pc_in        (pc_in),
        .wb_en0       (wb_en0),
        .wb_addr0     (wb_addr0),
        .wb_data0     (wb_data0),
        .wb_en1       (wb_en1),
        .wb_addr1     (wb_addr1),
        .wb_data1     (wb_data1),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .wr_collision (wr_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int k, input int a);
        rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    function automatic logic [WIDTH-1:0] rd(input int k);
        return rd_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        wb_en0 = 1'b0;
        wb_en1 = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; pc_in = 32'h100;
        wb_en0 = 0; wb_addr0 = '0; wb_data0 = '0;
        wb_en1 = 0; wb_addr1 = '0; wb_data1 = '0;
        rsv_en = 0; rsv_addr = '0;
        for (int i = 0; i < NUM_REGS; i++) expv[i] = WIDTH'(i);

        // Reset state
        tick();
        rst = 1'b0;
        set_ra(0, 0); set_ra(1, 1); set_ra(2, 2);
        #1;
        chk("reset_rd0", rd(0), 32'd0);
        chk("reset_rd1", rd(1), 32'd1);
        chk("reset_rd2", rd(2), 32'd2);
        chk("reset_pending", 32'(rd_pending), 32'd0);
        chk("reset_collision", 32'(wr_collision), 32'd0);
        set_ra(0, 15);
        #1;
        chk("pc_read", rd(0), 32'h100);
        chk("pc_pending", 32'(rd_pending[0]), 32'd0);

        // Same-cycle bypass on port 0
        tick();
        wb_en0 = 1; wb_addr0 = 3; wb_data0 = 32'hDEADBEEF;
        set_ra(0, 3); set_ra(1, 4);
        #1;
        chk("bypass_same_cycle", rd(0), 32'hDEADBEEF);
        chk("bypass_other_port", rd(1), 32'd4);
        tick();
        idle();
        #1;
        chk("bypass_stored", rd(0), 32'hDEADBEEF);
        expv[3] = 32'hDEADBEEF;

        // Dual write same register: port 0 wins, collision pulse
        wb_en0 = 1; wb_addr0 = 5; wb_data0 = 32'hAA;
        wb_en1 = 1; wb_addr1 = 5; wb_data1 = 32'hBB;
        set_ra(0, 5);
        #1;
        chk("dual_bypass_prio", rd(0), 32'hAA);
        chk("collision_not_yet", 32'(wr_collision), 32'd0);
        tick();
        idle();
        #1;
        chk("collision_pulse", 32'(wr_collision), 32'd1);
        chk("dual_stored", rd(0), 32'hAA);
        expv[5] = 32'hAA;
        tick();
        chk("collision_drop", 32'(wr_collision), 32'd0);

        // Dual write different registers
        wb_en0 = 1; wb_addr0 = 1; wb_data0 = 32'h11;
        wb_en1 = 1; wb_addr1 = 2; wb_data1 = 32'h22;
        set_ra(1, 2);
        #1;
        chk("port1_bypass", rd(1), 32'h22);
        tick();
        idle();
        set_ra(0, 1);
        #1;
        chk("diff_no_collision", 32'(wr_collision), 32'd0);
        chk("diff_r1", rd(0), 32'h11);
        chk("diff_r2", rd(1), 32'h22);
        expv[1] = 32'h11; expv[2] = 32'h22;

        // Writes to the virtual PC address are dropped
        wb_en0 = 1; wb_addr0 = 15; wb_data0 = 32'hFFFFFFFF;
        wb_en1 = 1; wb_addr1 = 15; wb_data1 = 32'h1234;
        set_ra(0, 15);
        #1;
        chk("pc_over_bypass", rd(0), 32'h100);
        tick();
        idle();
        #1;
        chk("pc_write_no_collision", 32'(wr_collision), 32'd0);
        for (int i = 0; i < NUM_REGS; i += RD_PORTS) begin
            for (int k = 0; k < RD_PORTS; k++) set_ra(k, i + k);
            #1;
            for (int k = 0; k < RD_PORTS; k++) chk($sformatf("regs_r%0d", i + k), rd(k), expv[i + k]);
        end

        // Scoreboard: reserve, then clear by writeback
        rsv_en = 1; rsv_addr = 4;
        set_ra(0, 4); set_ra(1, 5); set_ra(2, 15);
        #1;
        chk("rsv_not_yet", 32'(rd_pending[0]), 32'd0);
        tick();
        idle();
        #1;
        chk("rsv_pending", 32'(rd_pending), 32'b001);
        wb_en0 = 1; wb_addr0 = 4; wb_data0 = 32'h44;
        #1;
        chk("wb_hides_pending", 32'(rd_pending[0]), 32'd0);
        chk("wb_bypass_data", rd(0), 32'h44);
        tick();
        idle();
        #1;
        chk("pending_cleared", 32'(rd_pending[0]), 32'd0);
        chk("r4_stored", rd(0), 32'h44);

        // Clear through write port 1
        rsv_en = 1; rsv_addr = 7; set_ra(1, 7);
        tick();
        idle();
        #1;
        chk("rsv_r7", 32'(rd_pending[1]), 32'd1);
        wb_en1 = 1; wb_addr1 = 7; wb_data1 = 32'h70;
        tick();
        idle();
        #1;
        chk("r7_cleared_port1", 32'(rd_pending[1]), 32'd0);

        // Reserve beats clear on the same edge
        rsv_en = 1; rsv_addr = 4;
        wb_en0 = 1; wb_addr0 = 4; wb_data0 = 32'h45;
        tick();
        idle();
        #1;
        chk("rsv_beats_clear", 32'(rd_pending[0]), 32'd1);
        chk("rsv_beats_data", rd(0), 32'h45);

        // Mid-operation reset
        rsv_en = 1; rsv_addr = 6;
        wb_en0 = 1; wb_addr0 = 6; wb_data0 = 32'h77;
        set_ra(1, 6);
        tick();
        idle();
        #1;
        chk("r6_pending", 32'(rd_pending[1]), 32'd1);
        chk("r6_value", rd(1), 32'h77);
        rst = 1;
        wb_en0 = 1; wb_addr0 = 6; wb_data0 = 32'h99;
        wb_en1 = 1; wb_addr1 = 6; wb_data1 = 32'h55;
        rsv_en = 1; rsv_addr = 8;
        tick();
        rst = 0;
        idle();
        set_ra(0, 4); set_ra(2, 8);
        #1;
        chk("rst_r6", rd(1), 32'd6);
        chk("rst_r4", rd(0), 32'd4);
        chk("rst_pending", 32'(rd_pending), 32'd0);
        chk("rst_collision", 32'(wr_collision), 32'd0);
        set_ra(0, 3);
        #1;
        chk("rst_r3", rd(0), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
